// File: rtl/uart_prog_dump_tx.sv
// Instruction store readback: streams count then words LSB-first
// over a single 8N1 serializer, fetching each word on demand.
module uart_prog_dump_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [15:0] word_count,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int BW = $clog2(BAUD_CNT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LSB,
    S_CNT_MSB,
    S_FETCH,
    S_WAIT,
    S_LSB,
    S_MSB,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]   r_count;
  logic [15:0]   r_index;
  logic [15:0]   r_word;
  logic [9:0]    r_frame;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic          r_tx_act;

  logic       w_frame_done;
  logic       w_last;
  logic       w_load;
  logic       w_accept;
  logic       w_capture;
  logic       w_inc;
  logic [7:0] w_byte;

  assign w_frame_done = r_tx_act && (r_baud == BAUD_LAST)
                     && (r_bit == 4'd9);
  assign w_last = (16'(r_index + 16'd1) == r_count);
  assign mem_addr = r_index;
  // Idle line is high whenever no frame is in flight, including in reset
  assign tx = r_tx_act ? r_frame[0] : 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_byte    = 8'h00;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_inc     = 1'b0;
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_load   = 1'b1;
          w_byte   = word_count[7:0];
          w_next   = S_CNT_LSB;
        end
      end
      S_CNT_LSB: begin
        busy = 1'b1;
        if (w_frame_done) begin
          w_load = 1'b1;
          w_byte = r_count[15:8];
          w_next = S_CNT_MSB;
        end
      end
      S_CNT_MSB: begin
        busy = 1'b1;
        if (w_frame_done)
          w_next = (r_count == 16'd0) ? S_FINISH : S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        busy      = 1'b1;
        w_capture = 1'b1;
        w_load    = 1'b1;
        w_byte    = mem_data[7:0];
        w_next    = S_LSB;
      end
      S_LSB: begin
        busy = 1'b1;
        if (w_frame_done) begin
          w_load = 1'b1;
          w_byte = r_word[15:8];
          w_next = S_MSB;
        end
      end
      S_MSB: begin
        busy = 1'b1;
        if (w_frame_done) begin
          w_inc  = 1'b1;
          w_next = w_last ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_count <= 16'd0;
      r_index <= 16'd0;
      r_word  <= 16'd0;
    end else begin
      if (w_accept) begin
        r_count <= word_count;
        r_index <= 16'd0;
      end
      if (w_capture) r_word <= mem_data;
      if (w_inc)     r_index <= r_index + 16'd1;
    end
  end

  // A load may coincide with the end of the previous stop bit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame  <= 10'h3FF;
      r_baud   <= '0;
      r_bit    <= 4'd0;
      r_tx_act <= 1'b0;
    end else if (w_load) begin
      r_frame  <= {1'b1, w_byte, 1'b0};
      r_baud   <= '0;
      r_bit    <= 4'd0;
      r_tx_act <= 1'b1;
    end else if (r_tx_act) begin
      if (r_baud == BAUD_LAST) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_tx_act <= 1'b0;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_frame <= {1'b1, r_frame[9:1]};
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_dump_tx.sv
// Bench for uart_prog_dump_tx: UART decoder scoreboard, memory model,
// latency and handshake checks, mid-frame reset.
module tb_uart_prog_dump_tx;

  localparam int BC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] word_count = 16'd0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = 16'd0;
  logic        tx;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:15];
  logic [7:0]  exp_q [$];
  logic [15:0] addr_q [$];

  int errors = 0;
  int checks = 0;

  uart_prog_dump_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD(100_000)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .start(start),
    .word_count(word_count),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk)
    if (mem_rd_en === 1'b1) mem_data <= mem[mem_addr[3:0]];

  always @(negedge clk)
    if (rst_n && mem_rd_en === 1'b1) addr_q.push_back(mem_addr);

  // Bench-side UART receiver: samples mid-bit, pops expected bytes
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % BC == BC / 2) begin
        int k;
        k = rx_cnt / BC;
        if (k == 0) begin
          chk("rx_start_bit", {31'd0, tx}, 32'd0);
        end else if (k <= 8) begin
          rx_sh[k-1] = tx;
        end else begin
          chk("rx_stop_bit", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) begin
            chk("rx_extra_byte", {24'd0, rx_sh}, 32'hFFFF_FFFF);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("rx_byte", {24'd0, rx_sh}, {24'd0, e});
          end
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic run_dump(input logic [15:0] wc,
                          input bit hold,
                          input int exp_lat);
    int  k;
    bit  got;
    exp_q.push_back(wc[7:0]);
    exp_q.push_back(wc[15:8]);
    for (int i = 0; i < int'(wc); i++) begin
      exp_q.push_back(mem[i][7:0]);
      exp_q.push_back(mem[i][15:8]);
    end
    addr_q.delete();
    @(negedge clk);
    word_count = wc;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    k = 0;
    got = 1'b0;
    while (k < exp_lat + 50 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy_after_start", {31'd0, busy}, 32'd1);
      if (hold && k == 150) word_count = 16'd5;
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("latency", k, exp_lat);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("all_bytes_rx", exp_q.size(), 32'd0);
    chk("rd_count", addr_q.size(), {16'd0, wc});
    for (int i = 0; i < addr_q.size(); i++)
      chk("rd_addr", {16'd0, addr_q[i]}, i);
    exp_q.delete();
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_dump(16'd0, 1'b0, 201);

    mem[0] = 16'hA5C3;
    mem[1] = 16'h1234;
    run_dump(16'd2, 1'b0, 605);

    // start stays high across done and word_count moves mid-dump
    run_dump(16'd2, 1'b1, 605);
    addr_q.delete();
    repeat (300) @(negedge clk);
    chk("no_restart_busy", {31'd0, busy}, 32'd0);
    chk("no_restart_rd", addr_q.size(), 32'd0);

    mem[0] = 16'h5A3C;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h5A);
    @(negedge clk);
    word_count = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (k < 247) begin
      @(negedge clk);
      k++;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("midrst_addr", {16'd0, mem_addr}, 32'd0);
    chk("midrst_bytes_left", exp_q.size(), 32'd2);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mem[0] = 16'hBEEF;
    run_dump(16'd1, 1'b0, 403);

    mem[0] = 16'h0013;
    mem[1] = 16'hFF00;
    mem[2] = 16'h8001;
    run_dump(16'd3, 1'b0, 807);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
